// File: rtl/shared_counter_pkg.sv
// shared_counter_pkg: command encodings, FSM state constants and default sizing for shared_counter_pool.
package shared_counter_pkg;
  typedef enum logic [2:0] {
    CMD_IDLE    = 3'b000,
    CMD_ALLOC   = 3'b010,
    CMD_DEALLOC = 3'b011,
    CMD_LOAD    = 3'b100,
    CMD_READ    = 3'b101
  } cmd_op_e;
  typedef logic [0:0] fsm_state_e;
  localparam fsm_state_e ST_IDLE = 1'b0;
  localparam fsm_state_e ST_READ = 1'b1;
  localparam int DEF_NSLICE = 16;
  localparam int DEF_G = 4;
  localparam int DEF_LD_W = 64;
endpackage

// File: rtl/sc_first_fit.sv
// sc_first_fit: combinational search for the lowest base with size contiguous free slices.
module sc_first_fit
  import shared_counter_pkg::*;
#(
  parameter int NSLICE = DEF_NSLICE,
  parameter int ID_W = $clog2(NSLICE),
  parameter int SZ_W = $clog2(NSLICE) + 1
) (
  input  logic [NSLICE-1:0] free_map,
  input  logic [SZ_W-1:0]   size,
  output logic              found,
  output logic [ID_W-1:0]   base
);
  logic [NSLICE-1:0] fit;
  for (genvar b = 0; b < NSLICE; b++) begin : g_fit
    logic [NSLICE-1:0] win;
    assign win = ~({NSLICE{1'b1}} << size) << b;
    assign fit[b] = size != '0 && int'(size) <= NSLICE - b && (win & ~free_map) == '0;
  end
  always_comb begin
    found = |fit;
    base = '0;
    for (int i = NSLICE - 1; i >= 0; i--) if (fit[i]) base = ID_W'(i);
  end
endmodule

// File: rtl/shared_counter_pool.sv
// shared_counter_pool: pool of G-bit slices forming variable-size counters with alloc/dealloc/load/read and a concurrent increment port.
// Build option SATURATE_EN: increments of an all-ones counter hold all-ones instead of wrapping.
module shared_counter_pool
  import shared_counter_pkg::*;
#(
  parameter int NSLICE = DEF_NSLICE,
  parameter int G = DEF_G,
  parameter int LD_W = DEF_LD_W,
  parameter int ID_W = $clog2(NSLICE),
  parameter int SZ_W = $clog2(NSLICE) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [ID_W-1:0]      cmd_id,
  input  logic [SZ_W-1:0]      cmd_size,
  input  logic [LD_W-1:0]      load_data,
  input  logic                 inc_valid,
  input  logic [ID_W-1:0]      inc_id,
  output logic                 alloc_done,
  output logic                 alloc_ok,
  output logic [ID_W-1:0]      alloc_id,
  output logic [G-1:0]         rdata,
  output logic                 rdata_valid,
  output logic                 rdata_last,
  output logic                 ovf,
  output logic                 err,
  output logic [NSLICE-1:0]    free_map,
  output logic [NSLICE*G-1:0]  slice_data
);
  localparam int W = NSLICE * G;
  logic [NSLICE-1:0] free, head, live, mem_cmd, mem_inc, alloc_mask;
  logic [ID_W-1:0] owner [NSLICE];
  logic [W-1:0] data, data_nxt, snap;
  logic [SZ_W-1:0] len, left;
  fsm_state_e state;
  logic found, accept, do_alloc, alloc_hit, do_dealloc, do_load, do_read;
  logic cmd_bad, inc_bad, inc_hit, inc_ok, all_ones, sat, c;
  logic [ID_W-1:0] base;
  sc_first_fit #(.NSLICE(NSLICE), .ID_W(ID_W), .SZ_W(SZ_W)) u_fit (
    .free_map(free),
    .size(cmd_size),
    .found(found),
    .base(base)
  );
  // A used slice belongs to the nearest head at or below it.
  always_comb begin
    owner[0] = '0;
    live[0] = !free[0];
    for (int i = 1; i < NSLICE; i++) begin
      owner[i] = head[i] ? ID_W'(i) : owner[i-1];
      live[i] = !free[i] && (head[i] || live[i-1]);
    end
  end
  always_comb begin
    len = '0;
    for (int i = 0; i < NSLICE; i++) begin
      mem_cmd[i] = live[i] && owner[i] == cmd_id;
      mem_inc[i] = live[i] && owner[i] == inc_id;
      len = len + SZ_W'(mem_cmd[i]);
    end
  end
  assign cmd_ready = state == ST_IDLE;
  assign accept = cmd_valid && cmd_ready;
  assign do_alloc = accept && cmd_op == CMD_ALLOC;
  assign alloc_hit = do_alloc && found;
  assign do_dealloc = accept && cmd_op == CMD_DEALLOC && head[cmd_id];
  assign do_load = accept && cmd_op == CMD_LOAD && head[cmd_id];
  assign do_read = accept && cmd_op == CMD_READ && head[cmd_id];
  assign cmd_bad = accept && (cmd_op == CMD_DEALLOC || cmd_op == CMD_LOAD || cmd_op == CMD_READ) && !head[cmd_id];
  assign inc_bad = inc_valid && !head[inc_id];
  assign inc_hit = inc_valid && head[inc_id];
  // Dealloc or load of the same counter takes precedence over a same-cycle increment.
  assign inc_ok = inc_hit && !((do_dealloc || do_load) && cmd_id == inc_id);
  assign alloc_mask = ~({NSLICE{1'b1}} << cmd_size) << base;
  always_comb begin
    all_ones = 1'b1;
    for (int i = 0; i < NSLICE; i++) if (mem_inc[i] && data[i*G +: G] != '1) all_ones = 1'b0;
  end
`ifdef SATURATE_EN
  assign sat = all_ones;
`else
  assign sat = 1'b0;
`endif
  always_comb begin
    data_nxt = data;
    c = 1'b1;
    for (int i = 0; i < NSLICE; i++) begin
      if (inc_ok && !sat && mem_inc[i]) begin
        data_nxt[i*G +: G] = data[i*G +: G] + G'(c);
        c = c && data[i*G +: G] == '1;
      end
      if (do_load && mem_cmd[i]) data_nxt[i*G +: G] = G'(load_data >> ((i - int'(cmd_id)) * G));
      if ((do_dealloc && mem_cmd[i]) || (alloc_hit && alloc_mask[i])) data_nxt[i*G +: G] = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      free <= '1;
      head <= '0;
      snap <= '0;
      left <= '0;
      state <= ST_IDLE;
      alloc_done <= 1'b0;
      alloc_ok <= 1'b0;
      alloc_id <= '0;
      rdata <= '0;
      rdata_valid <= 1'b0;
      rdata_last <= 1'b0;
      ovf <= 1'b0;
      err <= 1'b0;
    end else begin
      data <= data_nxt;
      alloc_done <= do_alloc;
      alloc_ok <= alloc_hit;
      alloc_id <= alloc_hit ? base : '0;
      ovf <= inc_ok && all_ones;
      err <= cmd_bad || inc_bad;
      for (int i = 0; i < NSLICE; i++) begin
        if (do_dealloc && mem_cmd[i]) begin
          free[i] <= 1'b1;
          head[i] <= 1'b0;
        end
        if (alloc_hit && alloc_mask[i]) begin
          free[i] <= 1'b0;
          head[i] <= ID_W'(i) == base;
        end
      end
      if (state == ST_IDLE) begin
        rdata <= do_read ? data[cmd_id*G +: G] : '0;
        rdata_valid <= do_read;
        rdata_last <= do_read && len == SZ_W'(1);
        snap <= data >> (int'(cmd_id) * G + G);
        left <= len - 1'b1;
        state <= do_read ? ST_READ : ST_IDLE;
      end else begin
        rdata <= left != '0 ? snap[G-1:0] : '0;
        rdata_valid <= left != '0;
        rdata_last <= left == SZ_W'(1);
        snap <= snap >> G;
        left <= left != '0 ? left - 1'b1 : '0;
        state <= left != '0 ? ST_READ : ST_IDLE;
      end
    end
  end
  assign free_map = free;
  assign slice_data = data;
endmodule
